// File: rtl/cpu_writeback_if.sv
// Writeback-stage bundle: issue, execute/load results, decode queries and register-file write port.
// Forwarding outputs exist only when WRITEBACK_FORWARD_EN is defined.
interface cpu_writeback_if;
    logic        issue_valid_i;
    logic [3:0]  issue_index_i;
    logic        ex_valid_i;
    logic [3:0]  ex_index_i;
    logic [31:0] ex_value_i;
    logic        mem_valid_i;
    logic [3:0]  mem_index_i;
    logic [31:0] mem_value_i;
    logic        mem_ready_o;
    logic [3:0]  query_index1_i;
    logic [3:0]  query_index2_i;
    logic        hazard_o;
    logic [15:0] busy_o;
    logic        write_enable_o;
    logic [3:0]  reg_write_index_o;
    logic [31:0] value_o;
`ifdef WRITEBACK_FORWARD_EN
    logic        fwd_hit1_o;
    logic        fwd_hit2_o;
    logic [31:0] fwd_value1_o;
    logic [31:0] fwd_value2_o;
`endif

    modport slave (
        input  issue_valid_i, issue_index_i,
        input  ex_valid_i, ex_index_i, ex_value_i,
        input  mem_valid_i, mem_index_i, mem_value_i,
        output mem_ready_o,
        input  query_index1_i, query_index2_i,
        output hazard_o, busy_o,
`ifdef WRITEBACK_FORWARD_EN
        output fwd_hit1_o, fwd_hit2_o, fwd_value1_o, fwd_value2_o,
`endif
        output write_enable_o, reg_write_index_o, value_o
    );

    modport master (
        output issue_valid_i, issue_index_i,
        output ex_valid_i, ex_index_i, ex_value_i,
        output mem_valid_i, mem_index_i, mem_value_i,
        input  mem_ready_o,
        output query_index1_i, query_index2_i,
        input  hazard_o, busy_o,
`ifdef WRITEBACK_FORWARD_EN
        input  fwd_hit1_o, fwd_hit2_o, fwd_value1_o, fwd_value2_o,
`endif
        input  write_enable_o, reg_write_index_o, value_o
    );
endinterface

// File: rtl/cpu_writeback.sv
// Writeback stage: execute/load merge with a load FIFO, register-file write port and pending scoreboard.
// Optional WRITEBACK_FORWARD_EN adds write-port forwarding to decode and masks forwarded hazards.
module cpu_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    cpu_writeback_if.slave  wb
);
    logic [3:0]  fifo_idx [DEPTH];
    logic [31:0] fifo_val [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic full;
    logic empty;
    logic push;
    logic pop;

    logic        we_q;
    logic [3:0]  idx_q;
    logic [31:0] val_q;
    logic [15:0] busy_q;
    logic [15:0] busy_next;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wb.mem_valid_i && !full;
    // Execute always wins the write port; the FIFO head only drains on idle execute cycles.
    assign pop   = !wb.ex_valid_i && !empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_idx[wr_ptr] <= wb.mem_index_i;
            fifo_val[wr_ptr] <= wb.mem_value_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q  <= 1'b0;
            idx_q <= '0;
            val_q <= '0;
        end else if (wb.ex_valid_i) begin
            we_q  <= 1'b1;
            idx_q <= wb.ex_index_i;
            val_q <= wb.ex_value_i;
        end else if (pop) begin
            we_q  <= 1'b1;
            idx_q <= fifo_idx[rd_ptr];
            val_q <= fifo_val[rd_ptr];
        end else begin
            we_q  <= 1'b0;
        end
    end

    // Set after clear so a re-issue to the register being written stays pending.
    always_comb begin
        busy_next = busy_q;
        if (we_q) busy_next[idx_q] = 1'b0;
        if (wb.issue_valid_i) busy_next[wb.issue_index_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) busy_q <= '0;
        else        busy_q <= busy_next;
    end

    assign wb.mem_ready_o       = !full;
    assign wb.busy_o            = busy_q;
    assign wb.write_enable_o    = we_q;
    assign wb.reg_write_index_o = idx_q;
    assign wb.value_o           = val_q;

`ifdef WRITEBACK_FORWARD_EN
    logic hit1;
    logic hit2;
    assign hit1            = we_q && (idx_q == wb.query_index1_i);
    assign hit2            = we_q && (idx_q == wb.query_index2_i);
    assign wb.fwd_hit1_o   = hit1;
    assign wb.fwd_hit2_o   = hit2;
    assign wb.fwd_value1_o = val_q;
    assign wb.fwd_value2_o = val_q;
    assign wb.hazard_o     = (busy_q[wb.query_index1_i] && !hit1) ||
                             (busy_q[wb.query_index2_i] && !hit2);
`else
    assign wb.hazard_o     = busy_q[wb.query_index1_i] || busy_q[wb.query_index2_i];
`endif
endmodule

// File: tb/tb_cpu_writeback.sv
// Self-checking bench for cpu_writeback: a write-order scoreboard fed by a small model, plus per-scenario checks.
module tb_cpu_writeback;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] val;
    } wr_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int checks = 0;
    int errors = 0;

    wr_t        exp_q [$];
    wr_t        lq [$];
    logic [3:0] wr_log [$];
    logic [15:0] m_busy = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_idx = '0;

    cpu_writeback_if wb();

    cpu_writeback #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (wb)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_i && wb.write_enable_o) begin
            wr_t e;
            checks++;
            wr_log.push_back(wb.reg_write_index_o);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write idx=%0h val=%08h (no write expected)",
                         wb.reg_write_index_o, wb.value_o);
            end else begin
                e = exp_q.pop_front();
                if (wb.reg_write_index_o !== e.idx || wb.value_o !== e.val) begin
                    errors++;
                    $display("FAIL write_order got idx=%0h val=%08h expected idx=%0h val=%08h",
                             wb.reg_write_index_o, wb.value_o, e.idx, e.val);
                end
            end
        end
    end

    task automatic drive_idle();
        wb.issue_valid_i = 0; wb.issue_index_i = 0;
        wb.ex_valid_i = 0; wb.ex_index_i = 0; wb.ex_value_i = 0;
        wb.mem_valid_i = 0; wb.mem_index_i = 0; wb.mem_value_i = 0;
        wb.query_index1_i = 0; wb.query_index2_i = 0;
    endtask

    task automatic model_reset();
        exp_q.delete(); lq.delete();
        m_busy = '0; m_we = 1'b0; m_idx = '0;
    endtask

    // Apply inputs for one edge, advance the reference model, then land at posedge+1.
    task automatic cycle(input logic ex_v, input logic [3:0] ex_idx, input logic [31:0] ex_val,
                         input logic mem_v, input logic [3:0] mem_idx, input logic [31:0] mem_val,
                         input logic iss_v, input logic [3:0] iss_idx);
        wr_t e;
        logic [15:0] nb;
        bit acc;
        wb.ex_valid_i = ex_v; wb.ex_index_i = ex_idx; wb.ex_value_i = ex_val;
        wb.mem_valid_i = mem_v; wb.mem_index_i = mem_idx; wb.mem_value_i = mem_val;
        wb.issue_valid_i = iss_v; wb.issue_index_i = iss_idx;
        acc = mem_v && (lq.size() < DEPTH);
        nb = m_busy;
        if (m_we) nb[m_idx] = 1'b0;
        if (iss_v) nb[iss_idx] = 1'b1;
        if (ex_v) begin
            e.idx = ex_idx; e.val = ex_val;
            exp_q.push_back(e);
            m_we = 1'b1; m_idx = ex_idx;
        end else if (lq.size() != 0) begin
            e = lq.pop_front();
            exp_q.push_back(e);
            m_we = 1'b1; m_idx = e.idx;
        end else begin
            m_we = 1'b0;
        end
        if (acc) begin
            e.idx = mem_idx; e.val = mem_val;
            lq.push_back(e);
        end
        m_busy = nb;
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive_idle();
        rst_i = 1'b0;
        #3;
        checks++;
        if (wb.write_enable_o !== 1'b0 || wb.reg_write_index_o !== 4'h0 || wb.value_o !== 32'h0 ||
            wb.busy_o !== 16'h0 || wb.mem_ready_o !== 1'b1 || wb.hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state we=%b idx=%0h val=%08h busy=%04h rdy=%b hz=%b expected all zero, rdy=1",
                     wb.write_enable_o, wb.reg_write_index_o, wb.value_o, wb.busy_o, wb.mem_ready_o, wb.hazard_o);
        end
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_execute();
        cycle(0, 0, 0, 0, 0, 0, 1, 4'h3);
        wb.query_index1_i = 4'h3; #1;
        checks++;
        if (wb.busy_o[3] !== 1'b1 || wb.hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL exec_busy_set busy3=%b hazard=%b expected 1 1", wb.busy_o[3], wb.hazard_o);
        end
        cycle(1, 4'h3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        checks++;
        if (wb.write_enable_o !== 1'b1 || wb.reg_write_index_o !== 4'h3 || wb.value_o !== 32'hDEADBEEF ||
            wb.busy_o[3] !== 1'b1) begin
            errors++;
            $display("FAIL exec_write we=%b idx=%0h val=%08h busy3=%b expected 1 3 deadbeef 1",
                     wb.write_enable_o, wb.reg_write_index_o, wb.value_o, wb.busy_o[3]);
        end
        idle(1);
        checks++;
        if (wb.busy_o[3] !== 1'b0 || wb.write_enable_o !== 1'b0 || wb.hazard_o !== 1'b0) begin
            errors++;
            $display("FAIL exec_busy_clear busy3=%b we=%b hazard=%b expected 0 0 0",
                     wb.busy_o[3], wb.write_enable_o, wb.hazard_o);
        end
        wb.query_index1_i = 0;
    endtask

    task automatic test_priority();
        wr_log.delete();
        cycle(0, 0, 0, 1, 4'h5, 32'h11111111, 0, 0);
        cycle(1, 4'h6, 32'h66666666, 0, 0, 0, 0, 0);
        cycle(1, 4'h7, 32'h77777777, 0, 0, 0, 0, 0);
        cycle(1, 4'h8, 32'h88888888, 0, 0, 0, 0, 0);
        idle(3);
        checks++;
        if (wr_log.size() != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL prio_count writes=%0d pending=%0d expected 4 0", wr_log.size(), exp_q.size());
        end else begin
            checks++;
            if (wr_log[0] !== 4'h6 || wr_log[1] !== 4'h7 || wr_log[2] !== 4'h8 || wr_log[3] !== 4'h5) begin
                errors++;
                $display("FAIL prio_order got %0h %0h %0h %0h expected 6 7 8 5",
                         wr_log[0], wr_log[1], wr_log[2], wr_log[3]);
            end
        end
    endtask

    task automatic test_fifo_full();
        wr_log.delete();
        cycle(1, 4'h1, 32'hA0000001, 1, 4'hC, 32'hC0C0C0C0, 0, 0);
        cycle(1, 4'h1, 32'hA0000002, 1, 4'hD, 32'hD0D0D0D0, 0, 0);
        cycle(1, 4'h1, 32'hA0000003, 1, 4'hE, 32'hE0E0E0E0, 0, 0);
        checks++;
        if (wb.mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL fifo_three_ready got %b expected 1", wb.mem_ready_o);
        end
        cycle(1, 4'h1, 32'hA0000004, 1, 4'hF, 32'hF0F0F0F0, 0, 0);
        checks++;
        if (wb.mem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full_ready got %b expected 0", wb.mem_ready_o);
        end
        cycle(1, 4'h1, 32'hA0000005, 1, 4'h0, 32'hBADBAD00, 0, 0);
        checks++;
        if (wb.mem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_reject_ready got %b expected 0", wb.mem_ready_o);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wb.mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL fifo_ready_after_pop got %b expected 1", wb.mem_ready_o);
        end
        idle(4);
        checks++;
        if (wr_log.size() != 9 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_count writes=%0d pending=%0d expected 9 0", wr_log.size(), exp_q.size());
        end else begin
            checks++;
            if (wr_log[5] !== 4'hC || wr_log[6] !== 4'hD || wr_log[7] !== 4'hE || wr_log[8] !== 4'hF) begin
                errors++;
                $display("FAIL fifo_order got %0h %0h %0h %0h expected c d e f",
                         wr_log[5], wr_log[6], wr_log[7], wr_log[8]);
            end
        end
    endtask

    task automatic test_collision();
        cycle(1, 4'h2, 32'h22222222, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 4'h2);
        wb.query_index1_i = 4'h2; #1;
        checks++;
        if (wb.busy_o[2] !== 1'b1 || wb.hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL collision busy2=%b hazard=%b expected 1 1", wb.busy_o[2], wb.hazard_o);
        end
        cycle(1, 4'h2, 32'h22220000, 0, 0, 0, 0, 0);
        idle(1);
        checks++;
        if (wb.busy_o !== m_busy || wb.busy_o !== 16'h0) begin
            errors++;
            $display("FAIL collision_cleanup busy=%04h expected 0000", wb.busy_o);
        end
        wb.query_index1_i = 0;
    endtask

    task automatic test_forward();
        cycle(0, 0, 0, 0, 0, 0, 1, 4'h9);
        cycle(1, 4'h9, 32'h12345678, 0, 0, 0, 0, 0);
        wb.query_index1_i = 4'h0; wb.query_index2_i = 4'h9; #1;
        checks++;
        if (wb.busy_o[9] !== 1'b1) begin
            errors++;
            $display("FAIL fwd_busy9 got %b expected 1", wb.busy_o[9]);
        end
`ifdef WRITEBACK_FORWARD_EN
        checks++;
        if (wb.fwd_hit2_o !== 1'b1 || wb.fwd_value2_o !== 32'h12345678 || wb.hazard_o !== 1'b0 ||
            wb.fwd_hit1_o !== 1'b0) begin
            errors++;
            $display("FAIL fwd_hit hit2=%b val2=%08h hazard=%b hit1=%b expected 1 12345678 0 0",
                     wb.fwd_hit2_o, wb.fwd_value2_o, wb.hazard_o, wb.fwd_hit1_o);
        end
`else
        checks++;
        if (wb.hazard_o !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_hazard got %b expected 1", wb.hazard_o);
        end
`endif
        idle(1);
        wb.query_index2_i = 0;
    endtask

    task automatic test_reset_midrun();
        cycle(1, 4'h1, 32'h01010101, 1, 4'h5, 32'h55555555, 1, 4'h2);
        cycle(1, 4'h1, 32'h01010102, 1, 4'h6, 32'h66666666, 1, 4'h4);
        checks++;
        if (wb.busy_o !== 16'h0014 || wb.write_enable_o !== 1'b1 || lq.size() != 2) begin
            errors++;
            $display("FAIL midrun_setup busy=%04h we=%b expected 0014 1", wb.busy_o, wb.write_enable_o);
        end
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (wb.write_enable_o !== 1'b0 || wb.reg_write_index_o !== 4'h0 || wb.value_o !== 32'h0 ||
            wb.busy_o !== 16'h0 || wb.mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midrun_async we=%b idx=%0h val=%08h busy=%04h rdy=%b expected 0 0 0 0000 1",
                     wb.write_enable_o, wb.reg_write_index_o, wb.value_o, wb.busy_o, wb.mem_ready_o);
        end
        drive_idle();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        idle(6);
        checks++;
        if (wb.mem_ready_o !== 1'b1 || wb.write_enable_o !== 1'b0 || wb.busy_o !== 16'h0) begin
            errors++;
            $display("FAIL midrun_after rdy=%b we=%b busy=%04h expected 1 0 0000",
                     wb.mem_ready_o, wb.write_enable_o, wb.busy_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_execute();
        test_priority();
        test_fifo_full();
        test_collision();
        test_forward();
        test_reset_midrun();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Writeback stage: the producer side of the register-file write port. It owns write_enable/index/value toward the 16-entry register file (fp, sp, r0..r13, indices 0x0..0xF).
- Merges execute-stage results with memory-load results. Load results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can detect read-after-write hazards before issuing register-file reads.

Parameters:
- DEPTH, 4, load-result FIFO depth in entries; power of two, minimum 2.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  decode issues an instruction that will write issue_index_i.
- issue_index_i  in  4  destination register of the issued instruction.
- ex_valid_i  in  1  execute result valid this cycle; always accepted.
- ex_index_i  in  4  execute destination register.
- ex_value_i  in  32  execute result.
- mem_valid_i  in  1  load result valid.
- mem_index_i  in  4  load destination register.
- mem_value_i  in  32  load data.
- mem_ready_o  out  1  FIFO can accept; equals !full.
- query_index1_i  in  4  decode operand 1 register.
- query_index2_i  in  4  decode operand 2 register.
- hazard_o  out  1  combinational; high if either queried register is pending.
- busy_o  out  16  scoreboard pending bits, bit n = register index n.
- write_enable_o  out  1  register-file write strobe (registered).
- reg_write_index_o  out  4  register-file write index (registered).
- value_o  out  32  register-file write data (registered).

Behaviour:
- Reset (rst_i low, asynchronous):
  - write_enable_o=0, reg_write_index_o=0, value_o=0.
  - busy_o=0; FIFO empty (pointers 0, count 0).
  - mem_ready_o=1.
  - Inputs are ignored while rst_i is low.
  - A reset mid-operation discards all buffered loads and pending bits; nothing is written afterwards.
- FIFO push: when mem_valid_i && mem_ready_o at an edge.
  - mem_ready_o depends only on full; there is no same-cycle pass-through when full.
  - mem_valid_i while full is not accepted; the source holds the result.
- Write selection each edge:
  - If ex_valid_i, register {1, ex_index_i, ex_value_i} onto the write port.
  - Else if FIFO not empty, pop the head and register {1, index, value}.
  - Else write_enable_o=0; index and value hold their previous values.
  - Execute always has priority; the FIFO head waits while ex_valid_i is high.
- Latency:
  - An execute result appears on the write port 1 cycle after ex_valid_i.
  - A load appears at the earliest 2 cycles after acceptance (push edge, then pop edge).
- Simultaneous push and pop in the same edge: the count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Scoreboard, evaluated per edge:
  - Clear bit reg_write_index_o when write_enable_o=1.
  - Set bit issue_index_i when issue_valid_i=1.
  - If set and clear hit the same index in the same edge, set wins.
- hazard_o = busy_o[query_index1_i] | busy_o[query_index2_i].
- Decode is responsible for not issuing to a register that is already pending; this block does not count multiple outstanding writes.
- All 16 indices are writable; no register is hardwired.

Optional Feature:
- Macro: WRITEBACK_FORWARD_EN.
- Defined:
  - Adds outputs fwd_hit1_o, fwd_hit2_o (1 bit each) and fwd_value1_o, fwd_value2_o (32 bits each).
  - fwd_hitN_o = write_enable_o && reg_write_index_o==query_indexN_i; fwd_valueN_o = value_o.
  - A queried register with fwd_hitN_o high does not contribute to hazard_o.
- Undefined:
  - These ports are absent.
  - hazard_o is exactly the scoreboard lookup above.

Test Plan:
- Reset check: assert rst_i low mid-run with FIFO holding 2 entries and busy_o=0x0014 -> outputs go to 0 immediately without a clock edge; after release, mem_ready_o=1 and no write_enable_o pulse ever occurs.
- Execute path: issue idx 3; next cycle ex_valid_i with idx 3, value 0xDEADBEEF -> one cycle later write_enable_o=1, index 3, value 0xDEADBEEF; busy_o[3] is 1 until that edge and 0 the cycle after.
- Priority: load (idx 5, 0x11111111) accepted, then 3 consecutive execute results (idx 6, 7, 8) -> writes occur in order 6, 7, 8, then 5; the load is not lost.
- FIFO full: push 4 loads with ex_valid_i held high -> mem_ready_o=0 after the 4th; a 5th mem_valid_i is not accepted; drop ex_valid_i -> 4 writes in FIFO order, and mem_ready_o returns to 1 after the first pop.
- Set/clear collision: while write_enable_o=1 for idx 2, assert issue_valid_i for idx 2 -> busy_o[2] stays 1; query_index1_i=2 gives hazard_o=1.
- With WRITEBACK_FORWARD_EN: query_index2_i=9 while write_enable_o=1, index 9, value 0x12345678 -> fwd_hit2_o=1, fwd_value2_o=0x12345678, hazard_o=0 even though busy_o[9]=1.
